// File: rtl/pred_weighted_sum.sv
// pred_weighted_sum: angular/planar weighted-sum sample generator.
// Captures one 4x4 sub-block and emits it one row per output handshake.
module pred_weighted_sum #(
  parameter int BIT_DEPTH = 8,
  parameter int W_WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     angle_or_planar,
  input  logic [2:0]               log2_size,
  input  logic [16*W_WIDTH-1:0]    w1_bus,
  input  logic [16*W_WIDTH-1:0]    w2_bus,
  input  logic [16*BIT_DEPTH-1:0]  ref_a_bus,
  input  logic [16*BIT_DEPTH-1:0]  ref_b_bus,
  input  logic [BIT_DEPTH-1:0]     top_right,
  input  logic [BIT_DEPTH-1:0]     bottom_left,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4*BIT_DEPTH-1:0]   pred_row,
  output logic [1:0]               row_idx,
  output logic                     blk_last
);

  localparam int PB = W_WIDTH + BIT_DEPTH;
  localparam int AW = PB + 2;
  localparam int PW = PB + 4;
  localparam logic [BIT_DEPTH-1:0] MAXV = '1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e state_q, state_d;
  logic   rdy_q;
  logic   cap;
  logic   mode_q;
  logic [2:0] lg_q, lg_eff;
  logic [16*W_WIDTH-1:0]   w1_q, w2_q;
  logic [16*BIT_DEPTH-1:0] ra_q, rb_q;
  logic [BIT_DEPTH-1:0]    tr_q, bl_q;
  logic vld_q, vld_d;
  logic last_q, last_d;
  logic [1:0] row_q, row_d, sel;
  logic [4*BIT_DEPTH-1:0] pred_q, pred_d, row_nxt;

  function automatic logic [PB-1:0] mul(
    input logic [W_WIDTH-1:0]   w,
    input logic [BIT_DEPTH-1:0] s
  );
    return {{BIT_DEPTH{1'b0}}, w} * {{W_WIDTH{1'b0}}, s};
  endfunction

  function automatic logic [BIT_DEPTH-1:0] calc(
    input logic                 ang,
    input logic [2:0]           lg,
    input logic [W_WIDTH-1:0]   w1,
    input logic [W_WIDTH-1:0]   w2,
    input logic [BIT_DEPTH-1:0] a,
    input logic [BIT_DEPTH-1:0] b,
    input logic [BIT_DEPTH-1:0] tr,
    input logic [BIT_DEPTH-1:0] bl
  );
    logic [W_WIDTH-1:0]      n, f1, f2;
    logic signed [W_WIDTH:0] d1, d2;
    logic [AW-1:0]           acc_a;
    logic [PW-1:0]           acc_p, res;
    logic [2:0]              sh;
    n  = W_WIDTH'(1) << lg;
    d1 = $signed({1'b0, n}) - $signed({1'b0, w1});
    d2 = $signed({1'b0, n}) - $signed({1'b0, w2});
    // negative planar factors clamp to zero instead of wrapping
    f1 = d1[W_WIDTH] ? '0 : d1[W_WIDTH-1:0];
    f2 = d2[W_WIDTH] ? '0 : d2[W_WIDTH-1:0];
    sh = lg + 3'd1;
    acc_a = AW'(mul(w1, a)) + AW'(mul(w2, b)) + AW'(16);
    acc_p = PW'(mul(f1, a)) + PW'(mul(w1, tr))
          + PW'(mul(f2, b)) + PW'(mul(w2, bl)) + PW'(n);
    if (ang) res = PW'(acc_a >> 5);
    else     res = acc_p >> sh;
    return (res > PW'(MAXV)) ? MAXV : res[BIT_DEPTH-1:0];
  endfunction

  assign lg_eff = (lg_q >= 3'd2 && lg_q <= 3'd5) ? lg_q : 3'd2;
  assign sel    = vld_q ? row_q + 2'd1 : 2'd0;

  always_comb begin
    row_nxt = '0;
    for (int c = 0; c < 4; c++) begin
      int i;
      i = 4 * int'(sel) + c;
      row_nxt[c*BIT_DEPTH +: BIT_DEPTH] = calc(
        mode_q, lg_eff,
        w1_q[i*W_WIDTH +: W_WIDTH], w2_q[i*W_WIDTH +: W_WIDTH],
        ra_q[i*BIT_DEPTH +: BIT_DEPTH], rb_q[i*BIT_DEPTH +: BIT_DEPTH],
        tr_q, bl_q);
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    row_d   = row_q;
    pred_d  = pred_q;
    last_d  = last_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid && rdy_q) begin
          cap     = 1'b1;
          row_d   = 2'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!vld_q) begin
          vld_d  = 1'b1;
          row_d  = 2'd0;
          pred_d = row_nxt;
          last_d = 1'b0;
        end else if (out_ready) begin
          if (row_q == 2'd3) begin
            vld_d   = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            row_d  = sel;
            pred_d = row_nxt;
            last_d = (sel == 2'd3);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      pred_q  <= '0;
      mode_q  <= 1'b0;
      lg_q    <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      tr_q    <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      vld_q   <= vld_d;
      last_q  <= last_d;
      row_q   <= row_d;
      pred_q  <= pred_d;
      if (cap) begin
        mode_q <= angle_or_planar;
        lg_q   <= log2_size;
        w1_q   <= w1_bus;
        w2_q   <= w2_bus;
        ra_q   <= ref_a_bus;
        rb_q   <= ref_b_bus;
        tr_q   <= top_right;
        bl_q   <= bottom_left;
      end
    end
  end

  assign in_ready  = rdy_q && (state_q == IDLE);
  assign out_valid = vld_q;
  assign pred_row  = pred_q;
  assign row_idx   = row_q;
  assign blk_last  = last_q;

endmodule

// File: tb/tb_pred_weighted_sum.sv
// tb_pred_weighted_sum: scoreboard bench for pred_weighted_sum.
// Expected rows are queued on accept and popped as rows are handshaken.
module tb_pred_weighted_sum;
  localparam int BD = 8;
  localparam int WW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic angle_or_planar = 1'b0;
  logic out_ready = 1'b1;
  logic [2:0] log2_size = '0;
  logic [16*WW-1:0] w1_bus = '0;
  logic [16*WW-1:0] w2_bus = '0;
  logic [16*BD-1:0] ref_a_bus = '0;
  logic [16*BD-1:0] ref_b_bus = '0;
  logic [BD-1:0] top_right = '0;
  logic [BD-1:0] bottom_left = '0;
  logic in_ready, out_valid, blk_last;
  logic [4*BD-1:0] pred_row;
  logic [1:0] row_idx;

  pred_weighted_sum #(.BIT_DEPTH(BD), .W_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .angle_or_planar(angle_or_planar), .log2_size(log2_size),
    .w1_bus(w1_bus), .w2_bus(w2_bus),
    .ref_a_bus(ref_a_bus), .ref_b_bus(ref_b_bus),
    .top_right(top_right), .bottom_left(bottom_left),
    .out_valid(out_valid), .out_ready(out_ready),
    .pred_row(pred_row), .row_idx(row_idx), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pred;
    int          idx;
    bit          last;
  } exp_t;

  exp_t sbq[$];
  int bw1[16], bw2[16], bra[16], brb[16];
  int btr, bbl, bl2;
  bit bang;
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model(input int i);
    int l, n, f1, f2, v;
    if (bang) begin
      v = (bw1[i] * bra[i] + bw2[i] * brb[i] + 16) >> 5;
    end else begin
      l  = (bl2 < 2 || bl2 > 5) ? 2 : bl2;
      n  = 1 << l;
      f1 = n - bw1[i];
      f2 = n - bw2[i];
      if (f1 < 0) f1 = 0;
      if (f2 < 0) f2 = 0;
      v = (f1 * bra[i] + bw1[i] * btr + f2 * brb[i]
           + bw2[i] * bbl + n) >> (l + 1);
    end
    if (v > 255) v = 255;
    return v;
  endfunction

  function automatic logic [31:0] exp_row(input int r);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(model(4 * r + c));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uni(input bit ang, input int l2, input int w1,
                         input int w2, input int a, input int b,
                         input int tr, input int bl);
    bang = ang; bl2 = l2; btr = tr; bbl = bl;
    for (int i = 0; i < 16; i++) begin
      bw1[i] = w1; bw2[i] = w2; bra[i] = a; brb[i] = b;
    end
  endtask

  task automatic load_bus();
    for (int i = 0; i < 16; i++) begin
      w1_bus[i*WW +: WW]    = WW'(bw1[i]);
      w2_bus[i*WW +: WW]    = WW'(bw2[i]);
      ref_a_bus[i*BD +: BD] = BD'(bra[i]);
      ref_b_bus[i*BD +: BD] = BD'(brb[i]);
    end
    angle_or_planar = bang;
    log2_size = 3'(bl2);
    top_right = BD'(btr);
    bottom_left = BD'(bbl);
  endtask

  task automatic send();
    int n = 0;
    load_bus();
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      for (int r = 0; r < 4; r++) begin
        exp_t e;
        e.pred = exp_row(r);
        e.idx = r;
        e.last = (r == 3);
        sbq.push_back(e);
      end
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 100) begin
      tick();
      n++;
    end
    check("drain", sbq.size(), 0);
  endtask

  task automatic set_planar_ramp();
    set_uni(0, 2, 0, 0, 0, 0, 128, 0);
    for (int i = 0; i < 16; i++) begin
      bw1[i] = (i % 4) + 1;
      bw2[i] = (i / 4) + 1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_row", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("pred_row", pred_row, e.pred);
        check("row_idx", row_idx, e.idx);
        check("blk_last", blk_last, e.last);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_pred", pred_row, 0);
    check("rst_idx", row_idx, 0);
    check("rst_last", blk_last, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // angular full rate
    set_uni(1, 2, 8, 24, 100, 200, 0, 0);
    send();
    check("busy_ready", in_ready, 0);
    for (int r = 0; r < 4; r++) begin
      tick();
      check("row_valid", out_valid, 1);
      if (r == 0) check("ang_row0", pred_row, 32'hAFAFAFAF);
    end
    tick();
    check("ready_back", in_ready, 1);
    check("valid_drop", out_valid, 0);

    // planar ramp
    set_planar_ramp();
    send();
    tick();
    check("planar_row0", pred_row, 32'h40302010);
    drain();

    // backpressure on row 1 with ignored in_valid pulses
    set_uni(1, 2, 8, 24, 100, 200, 0, 0);
    send();
    tick();
    tick();
    check("bp_idx", row_idx, 1);
    out_ready = 1'b0;
    in_valid = 1'b1;
    w1_bus = '0;
    w2_bus = '0;
    repeat (3) begin
      tick();
      check("bp_hold_row", pred_row, 32'hAFAFAFAF);
      check("bp_hold_idx", row_idx, 1);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_last", blk_last, 0);
      in_valid = ~in_valid;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (3) tick();
    check("bp_no_ghost", out_valid, 0);

    // clipping
    set_uni(1, 2, 255, 255, 255, 255, 0, 0);
    send();
    tick();
    check("clip_ang", pred_row, 32'hFFFFFFFF);
    drain();
    set_uni(0, 2, 40, 0, 200, 50, 10, 20);
    for (int i = 0; i < 16; i++) bw2[i] = i;
    send();
    drain();
    set_uni(0, 2, 255, 255, 255, 255, 255, 255);
    send();
    drain();

    // random blocks, including illegal and max log2_size
    for (int k = 0; k < 8; k++) begin
      bang = k[0];
      bl2 = (k == 2) ? 5 : (k == 4) ? 7 : $urandom_range(0, 7);
      btr = $urandom_range(0, 255);
      bbl = $urandom_range(0, 255);
      for (int i = 0; i < 16; i++) begin
        bw1[i] = (k < 4) ? $urandom_range(0, 40) : $urandom_range(0, 255);
        bw2[i] = (k < 4) ? $urandom_range(0, 40) : $urandom_range(0, 255);
        bra[i] = $urandom_range(0, 255);
        brb[i] = $urandom_range(0, 255);
      end
      send();
      drain();
    end

    // reset during row 2
    set_uni(1, 2, 8, 24, 100, 200, 0, 0);
    send();
    repeat (3) tick();
    check("pre_rst_idx", row_idx, 2);
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", out_valid, 0);
    check("rst_async_idx", row_idx, 0);
    sbq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", out_valid, 0);
    set_planar_ramp();
    send();
    tick();
    check("post_rst_row0", pred_row, 32'h40302010);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
